// File: rtl/mem_byte_sequencer.sv
// Byte-serial, big-endian RAM access sequencer: each MFA request becomes 1, 2 or 4 single-byte
// RAM accesses answered by a one-cycle MOC. Defining MEM_ALIGN_CHECK_EN enables the misalignment trap.
module mem_byte_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        DataSize,
  input  logic              SignExt,
  input  logic [31:0]       Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Busy,
  output logic              AlignErr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_SETTLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_addr;
  logic              rw_q;
  logic              sext_q;
  logic              align_q;
  logic              mis_req;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       data_q;
  logic [31:0]       load_val;
  logic [2:0]        n_q;
  logic [2:0]        k_q;
  logic [2:0]        n_req;
  logic [2:0]        wait_cnt;
  logic [1:0]        byte_idx;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Address[31:ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_req  = ((DataSize == 2'b01) && Address[0]) ||
                    (DataSize[1] && (Address[1:0] != 2'b00));
  assign AlignErr = align_q;
`else
  assign mis_req  = 1'b0;
  assign AlignErr = 1'b0;
`endif

  always_comb begin
    case (DataSize)
      2'b00:   n_req = 3'd1;
      2'b01:   n_req = 3'd2;
      default: n_req = 3'd4;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (MFA) begin
          state_next = mis_req ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (WAIT_STATES > 0) begin
          state_next = S_WAIT;
        end else if ((k_q + 3'd1) < n_q) begin
          state_next = S_XFER;
        end else begin
          state_next = S_DONE;
        end
      end
      S_WAIT: begin
        // k_q was already advanced on leaving SETTLE
        if (wait_cnt == 3'd0) begin
          state_next = (k_q < n_q) ? S_XFER : S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!MFA) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    byte_idx  = 2'(n_q - k_q - 3'd1);
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    if (state == S_XFER) begin
      ram_addr = base_addr + ADDR_W'(k_q);
      if (rw_q) begin
        ram_re = 1'b1;
      end else begin
        ram_we = 1'b1;
        case (byte_idx)
          2'd0:    ram_wdata = wdata_q[7:0];
          2'd1:    ram_wdata = wdata_q[15:8];
          2'd2:    ram_wdata = wdata_q[23:16];
          default: ram_wdata = wdata_q[31:24];
        endcase
      end
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{sext_q & asm_q[7]}}, asm_q[7:0]};
      2'b01:   load_val = {{16{sext_q & asm_q[15]}}, asm_q[15:0]};
      default: load_val = asm_q;
    endcase
  end

  assign MOC  = (state == S_DONE);
  assign Busy = (state == S_XFER) || (state == S_SETTLE) || (state == S_WAIT);

  // The load result is presented combinationally in DONE so it coincides with MOC.
  assign DataOut = ((state == S_DONE) && rw_q && !align_q) ? load_val : data_q;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state     <= S_IDLE;
      base_addr <= '0;
      rw_q      <= 1'b0;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      wdata_q   <= 32'h0;
      n_q       <= 3'd0;
      k_q       <= 3'd0;
      wait_cnt  <= 3'd0;
      asm_q     <= 32'h0;
      data_q    <= 32'h0;
      align_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (MFA) begin
            base_addr <= Address[ADDR_W-1:0];
            rw_q      <= RW;
            size_q    <= DataSize;
            sext_q    <= SignExt;
            wdata_q   <= DataIn;
            n_q       <= n_req;
            k_q       <= 3'd0;
            asm_q     <= 32'h0;
            align_q   <= mis_req;
          end
        end
        S_SETTLE: begin
          k_q      <= k_q + 3'd1;
          wait_cnt <= WS_LOAD;
          if (rw_q) begin
            asm_q <= {asm_q[23:0], ram_rdata};
          end
        end
        S_WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
          if (rw_q && !align_q) begin
            data_q <= load_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Sits between the datapath control FSM (MAR/MDR side) and the byte-wide instruction/data RAM.
- Converts one MFA request (byte, halfword or word; read or write) into a sequence of single-byte RAM accesses, big-endian.
- Answers with a one-cycle MOC pulse and, for loads, the assembled and extended 32-bit value.
- Lets the control FSM wait on MOC regardless of access size or RAM speed.

Parameters:
- ADDR_W, 9: RAM byte-address width (512 bytes).
- WAIT_STATES, 0: idle cycles inserted after each byte transfer, range 0–7.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Clear  in  1  synchronous, active-high reset.
- MFA  in  1  memory function activate; held high by the requester until MOC is seen.
- RW  in  1  1 = read (load), 0 = write (store).
- DataSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- SignExt  in  1  loads: 1 sign-extends, 0 zero-extends.
- Address  in  32  byte address; only [ADDR_W-1:0] used.
- DataIn  in  32  store data, right-justified.
- DataOut  out  32  load result.
- MOC  out  1  memory operation complete, one-cycle pulse.
- Busy  out  1  high from request acceptance until MOC.
- AlignErr  out  1  misaligned-access flag.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  8  RAM read byte; valid the cycle after ram_re.

Behaviour:
- Reset: when Clear=1 at an edge, state = IDLE. All of DataOut, MOC, Busy, AlignErr, ram_addr, ram_wdata, ram_we and ram_re = 0.
- Clear mid-transfer aborts immediately. Bytes already written stay written.
- States: IDLE, XFER, SETTLE, WAIT, DONE, HOLD.
- IDLE:
  - When MFA=1, latch Address, RW, DataSize, SignExt and DataIn.
  - Set N = 1, 2 or 4; set k = 0; clear AlignErr; set Busy=1; go to XFER.
- XFER (one cycle):
  - ram_addr = (Address[ADDR_W-1:0] + k) mod 2^ADDR_W; wraps at the top of RAM.
  - Read: ram_re=1.
  - Write: ram_we=1, with ram_wdata = byte (N-1-k) of the right-justified store data, so the MSB goes to the lowest address.
  - Next state: SETTLE.
- SETTLE (one cycle):
  - Strobes low.
  - Read: shift ram_rdata into the assembly register, LSB end, previous contents shifted left 8.
  - Next: k+1. Go to WAIT if WAIT_STATES>0, else to XFER if k+1<N, else to DONE.
- WAIT: hold for WAIT_STATES cycles with strobes low, then go to XFER or DONE by the same rule.
- DONE (one cycle):
  - MOC=1 and Busy=0.
  - Read: DataOut = assembled value extended from 8/16 bits per SignExt (word unchanged).
  - Write: DataOut unchanged.
  - Next state: HOLD.
- HOLD: wait for MFA=0, then go to IDLE. A still-high MFA is never taken as a new request.
- Latency: with the MFA-sampling edge as cycle 0, MOC is high in cycle N*(2+WAIT_STATES)+1.
  - Word read with WAIT_STATES=0: cycle 9.
  - Byte access: cycle 3.
- MFA dropping mid-transfer is ignored; the transfer completes and MOC still pulses.
- DataOut holds its last load value until the next read completes.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A halfword with Address[0]=1, or a word with Address[1:0]≠0, is misaligned.
  - Misaligned access: IDLE goes directly to DONE, with no RAM strobes.
  - In that DONE cycle, MOC=1 and AlignErr=1 together; DataOut is unchanged.
  - AlignErr then stays high until the next accepted request.
- Undefined:
  - No alignment check; AlignErr is tied to 0.
  - Unaligned accesses proceed byte by byte from Address, with address wrap.

Test Plan:
- Word read, Mem[0..3]=12,34,56,78, WAIT_STATES=0 -> DataOut=0x12345678; MOC high only in cycle 9; four ram_re pulses at addresses 0,1,2,3.
- Byte read at 5 (Mem[5]=0x86), SignExt=1 -> 0xFFFFFF86 in cycle 3; repeat with SignExt=0 -> 0x00000086.
- Halfword write, DataIn=0x0000ABCD, Address=6 -> Mem[6]=AB, Mem[7]=CD; MOC in cycle 5; DataOut unchanged.
- Word read with MFA held high through HOLD for 3 extra cycles -> exactly one MOC pulse, no second transfer; a new MFA after a low cycle is accepted.
- Clear asserted after the second XFER of a word write to 0x10 of 0xDEADBEEF -> only Mem[0x10]=DE and Mem[0x11]=AD change; all outputs 0 next cycle; no MOC.
- Word read at 0x1FF:
  - MEM_ALIGN_CHECK_EN undefined -> reads 0x1FF,0x000,0x001,0x002.
  - Defined -> MOC and AlignErr high in cycle 1, no strobes.
  - WAIT_STATES=2 aligned word read -> MOC in cycle 17.
